// File: rtl/encode16x4_reqq_pkg.sv
// Shared definitions for the 16-to-4 request encoder.
//   N_SLOTS : number of request lines / pending bits
//   IDX_W   : width of an encoded slot index
//   state_e : handshake FSM states
package encode16x4_reqq_pkg;

  localparam int unsigned N_SLOTS = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/encode16x4_reqq_prio_enc16.sv
// Combinational priority encoder with a rotating start point.
// Ports:
//   vector [15:0] in  : candidate bits
//   base   [3:0]  in  : first index examined; scan wraps 15 -> 0
//   idx    [3:0]  out : first set index at or after base (0 when none)
//   any           out : at least one bit of vector is set
module prio_enc16
  import encode16x4_reqq_pkg::*;
(
  input  logic [N_SLOTS-1:0] vector,
  input  logic [IDX_W-1:0]   base,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic             found;
  logic [IDX_W-1:0] pos;

  always_comb begin
    idx   = '0;
    any   = |vector;
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      // 4-bit addition wraps modulo 16, giving the circular scan
      pos = base + IDX_W'(i);
      if (!found && vector[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encode16x4_reqq.sv
// Sequential 16-to-4 encoder: latches request pulses as sticky pending bits
// and hands out one slot index at a time over a valid/ready handshake.
// Parameters:
//   RR_EN  : 0 fixed priority (lowest index), 1 round-robin after last grant
//   OVR_EN : 1 flags a request landing on an already-pending slot
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   req[15:0]        : event pulses, bit i marks slot i pending
//   out_ready        : consumer accepts code this cycle
//   ovr_clr          : clears ovr_flag
//   out_valid        : code holds a pending index
//   code[3:0]        : granted slot index
//   pending[15:0]    : sticky pending register
//   ovr_flag         : sticky overrun indicator
module encode16x4_reqq
  import encode16x4_reqq_pkg::*;
#(
  parameter int unsigned RR_EN  = 0,
  parameter int unsigned OVR_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SLOTS-1:0] req,
  input  logic               out_ready,
  input  logic               ovr_clr,
  output logic               out_valid,
  output logic [IDX_W-1:0]   code,
  output logic [N_SLOTS-1:0] pending,
  output logic               ovr_flag
);

  state_e             state_q, state_d;
  logic [N_SLOTS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]   code_q, code_d;
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               ovr_q, ovr_d;

  logic               hs;
  logic [N_SLOTS-1:0] clr_mask;
  logic [N_SLOTS-1:0] pend_masked;
  logic [IDX_W-1:0]   sel_base;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;

  assign hs          = out_valid_q && out_ready;
  assign clr_mask    = hs ? (N_SLOTS'(1) << code_q) : '0;
  // Selection sees pending with the serviced bit removed but without this
  // cycle's req; in IDLE clr_mask is zero so this is plain pending.
  assign pend_masked = pending_q & ~clr_mask;

  always_comb begin
    pending_d = pend_masked | req;
    rr_ptr_d  = hs ? code_q + IDX_W'(1) : rr_ptr_q;
    ovr_d     = ovr_q;
    if ((OVR_EN != 0) && (|(req & pend_masked))) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  // rr_ptr_d already reflects a same-cycle grant, so back-to-back selection
  // starts after the slot being serviced.
  assign sel_base = (RR_EN != 0) ? rr_ptr_d : '0;

  prio_enc16 u_prio (
    .vector (pend_masked),
    .base   (sel_base),
    .idx    (sel_idx),
    .any    (sel_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      code_q      <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      code_q      <= code_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_any) state_d = PRESENT;
      PRESENT: if (hs && !sel_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    code_d      = code_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          code_d      = sel_idx;
          out_valid_d = 1'b1;
        end
      end
      PRESENT: begin
        if (hs) begin
          if (sel_any) begin
            code_d = sel_idx;
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  assign out_valid = out_valid_q;
  assign code      = code_q;
  assign pending   = pending_q;
  assign ovr_flag  = ovr_q;

endmodule

// File: tb/tb_encode16x4_reqq.sv
module tb_encode16x4_reqq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        out_ready;
  logic        ovr_clr;

  logic        v0, v1, o0, o1;
  logic [3:0]  c0, c1;
  logic [15:0] p0, p1;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  // dut0: fixed priority with overrun detection
  encode16x4_reqq #(.RR_EN(0), .OVR_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .out_valid(v0), .code(c0), .pending(p0), .ovr_flag(o0)
  );

  // dut1: round-robin, overrun detection disabled
  encode16x4_reqq #(.RR_EN(1), .OVR_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .out_valid(v1), .code(c1), .pending(p1), .ovr_flag(o1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; out_ready = 1'b0; ovr_clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 16'hFFFF; out_ready = 1'b1; ovr_clr = 1'b0;
    step(); step();
    tests_run++; if (p0 !== 16'h0000) begin failures++; $display("FAIL reset_pending0 got %h exp 0000", p0); end
    tests_run++; if (v0 !== 1'b0) begin failures++; $display("FAIL reset_valid0 got %b exp 0", v0); end
    tests_run++; if (o0 !== 1'b0) begin failures++; $display("FAIL reset_ovr0 got %b exp 0", o0); end
    tests_run++; if (c0 !== 4'd0) begin failures++; $display("FAIL reset_code0 got %0d exp 0", c0); end
    tests_run++; if (p1 !== 16'h0000 || v1 !== 1'b0) begin failures++; $display("FAIL reset_dut1 got p=%h v=%b exp p=0000 v=0", p1, v1); end
    rst_n = 1'b1; req = '0; out_ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1; req = 16'h0020;
    step();
    req = '0;
    tests_run++; if (p0 !== 16'h0020 || v0 !== 1'b0) begin failures++; $display("FAIL single_n1 got p=%h v=%b exp p=0020 v=0", p0, v0); end
    step();
    tests_run++; if (v0 !== 1'b1 || c0 !== 4'd5) begin failures++; $display("FAIL single_n2 got v=%b code=%0d exp v=1 code=5", v0, c0); end
    step();
    tests_run++; if (v0 !== 1'b0 || p0 !== 16'h0000) begin failures++; $display("FAIL single_done got v=%b p=%h exp v=0 p=0000", v0, p0); end
    out_ready = 1'b0;
  endtask

  task automatic test_priority_stall();
    do_reset();
    out_ready = 1'b0; req = 16'h8101;
    step();
    req = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (v0 !== 1'b1 || c0 !== 4'd0) begin failures++; $display("FAIL stall_hold%0d got v=%b code=%0d exp v=1 code=0", i, v0, c0); end
      step();
    end
    out_ready = 1'b1;
    step();
    tests_run++; if (v0 !== 1'b1 || c0 !== 4'd8) begin failures++; $display("FAIL prio_second got v=%b code=%0d exp v=1 code=8", v0, c0); end
    step();
    tests_run++; if (v0 !== 1'b1 || c0 !== 4'd15) begin failures++; $display("FAIL prio_third got v=%b code=%0d exp v=1 code=15", v0, c0); end
    step();
    tests_run++; if (v0 !== 1'b0 || p0 !== 16'h0000) begin failures++; $display("FAIL prio_done got v=%b p=%h exp v=0 p=0000", v0, p0); end
    out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    // Part 1: RR and fixed priority diverge after granting 3 with {0,5} pending.
    do_reset();
    req = 16'h0008;
    step();
    req = '0;
    step();
    tests_run++; if (c1 !== 4'd3 || v1 !== 1'b1) begin failures++; $display("FAIL rr_first got v=%b code=%0d exp v=1 code=3", v1, c1); end
    req = 16'h0021;
    step();
    req = '0; out_ready = 1'b1;
    step();
    tests_run++; if (c1 !== 4'd5 || c0 !== 4'd0) begin failures++; $display("FAIL rr_diverge got rr=%0d fix=%0d exp rr=5 fix=0", c1, c0); end
    step();
    tests_run++; if (c1 !== 4'd0 || c0 !== 4'd5) begin failures++; $display("FAIL rr_wrap got rr=%0d fix=%0d exp rr=0 fix=5", c1, c0); end
    step();
    tests_run++; if (v1 !== 1'b0 || v0 !== 1'b0) begin failures++; $display("FAIL rr_idle got rr_v=%b fix_v=%b exp 0 0", v1, v0); end

    // Part 2: 3 -> (wrap) 0 -> 3 with a re-request of 3 on its own handshake.
    do_reset();
    req = 16'h0008;
    step();
    req = '0;
    step();
    req = 16'h0001;
    step();
    req = 16'h0008; out_ready = 1'b1;
    step();
    req = '0;
    tests_run++; if (c1 !== 4'd0 || p1 !== 16'h0009) begin failures++; $display("FAIL rr_rereq got code=%0d p=%h exp code=0 p=0009", c1, p1); end
    tests_run++; if (o0 !== 1'b0) begin failures++; $display("FAIL rr_no_ovr got %b exp 0", o0); end
    step();
    tests_run++; if (c1 !== 4'd3 || v1 !== 1'b1) begin failures++; $display("FAIL rr_back3 got v=%b code=%0d exp v=1 code=3", v1, c1); end
    step();
    tests_run++; if (v1 !== 1'b0 || p1 !== 16'h0000) begin failures++; $display("FAIL rr_done got v=%b p=%h exp v=0 p=0000", v1, p1); end
    out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    req = 16'h0005;
    step();
    req = '0;
    step();
    req = 16'h0004;
    step();
    req = '0;
    tests_run++; if (o0 !== 1'b1) begin failures++; $display("FAIL ovr_set got %b exp 1", o0); end
    tests_run++; if (o1 !== 1'b0) begin failures++; $display("FAIL ovr_disabled got %b exp 0", o1); end
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    tests_run++; if (o0 !== 1'b0) begin failures++; $display("FAIL ovr_clear got %b exp 0", o0); end
    out_ready = 1'b1;
    step();
    tests_run++; if (c0 !== 4'd2 || v0 !== 1'b1) begin failures++; $display("FAIL ovr_code2 got v=%b code=%0d exp v=1 code=2", v0, c0); end
    req = 16'h0004;
    step();
    req = '0; out_ready = 1'b0;
    tests_run++; if (p0 !== 16'h0004 || o0 !== 1'b0 || v0 !== 1'b0) begin failures++; $display("FAIL set_wins got p=%h ovr=%b v=%b exp p=0004 ovr=0 v=0", p0, o0, v0); end
    step();
    tests_run++; if (c0 !== 4'd2 || v0 !== 1'b1) begin failures++; $display("FAIL regrant2 got v=%b code=%0d exp v=1 code=2", v0, c0); end
    req = 16'h0004; ovr_clr = 1'b1;
    step();
    req = '0;
    tests_run++; if (o0 !== 1'b1) begin failures++; $display("FAIL ovr_set_beats_clr got %b exp 1", o0); end
    step();
    ovr_clr = 1'b0;
    tests_run++; if (o0 !== 1'b0) begin failures++; $display("FAIL ovr_clear2 got %b exp 0", o0); end
  endtask

  task automatic test_mid_reset_drain();
    do_reset();
    req = 16'hFFFF;
    step();
    req = '0;
    step();
    tests_run++; if (v0 !== 1'b1 || p0 !== 16'hFFFF) begin failures++; $display("FAIL mid_pre got v=%b p=%h exp v=1 p=ffff", v0, p0); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests_run++; if (v0 !== 1'b0 || p0 !== 16'h0000 || c0 !== 4'd0) begin failures++; $display("FAIL mid_reset got v=%b p=%h code=%0d exp v=0 p=0000 code=0", v0, p0, c0); end

    req = 16'hFFFF; out_ready = 1'b1;
    step();
    req = '0;
    step();
    for (int i = 0; i < 16; i++) begin
      tests_run++; if (v0 !== 1'b1 || c0 !== 4'(i)) begin failures++; $display("FAIL drain_fix%0d got v=%b code=%0d exp v=1 code=%0d", i, v0, c0, i); end
      tests_run++; if (v1 !== 1'b1 || c1 !== 4'(i)) begin failures++; $display("FAIL drain_rr%0d got v=%b code=%0d exp v=1 code=%0d", i, v1, c1, i); end
      step();
    end
    tests_run++; if (v0 !== 1'b0 || p0 !== 16'h0000 || v1 !== 1'b0) begin failures++; $display("FAIL drain_done got v0=%b p0=%h v1=%b exp 0 0000 0", v0, p0, v1); end
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b0; ovr_clr = 1'b0;
    test_reset();
    test_single();
    test_priority_stall();
    test_round_robin();
    test_overrun();
    test_mid_reset_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
